// File: rtl/decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_sequencer
// Purpose  : Recovers the LFSR tap pattern and seed of a ciphertext block from
//            its space-filled preamble, then decrypts 64 bytes from data
//            memory addresses 64..127 into addresses 0..63.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk            in   1  sole clock, rising edge
//   Reset          in   1  asynchronous active-low reset
//   Start          in   1  high = armed/idle, falling edge launches a run
//   Ack            out  1  run complete, held until Start goes high
//   Fail           out  1  no tap pattern fits the preamble (valid with Ack)
//   mem_addr       out  8  data-memory address (read data one cycle later)
//   mem_rd_data    in   8  data-memory read data
//   mem_wr_en      out  1  one-cycle write strobe per decrypted byte
//   mem_wr_data    out  8  data-memory write data
//   ptrn_idx       out  4  selected tap pattern 0..8, 0xF after a failed search
//   lfsr_seed      out  7  recovered LFSR initial state
//   parity_err_cnt out  7  ciphertext bytes with bad parity (saturates at 64)
// Configuration
//   DECRYPT_PARITY_CHK_EN  when defined, adds the ciphertext parity counter;
//                          otherwise parity_err_cnt is tied to zero.
// ============================================================================
module decrypt_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       Fail,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] ptrn_idx,
    output logic [6:0] lfsr_seed,
    output logic [6:0] parity_err_cnt
);

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_DECRYPT = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [7:0] c_CT_BASE   = 8'd64;
    localparam logic [6:0] c_SPACE     = 7'h20;
    localparam logic [4:0] c_PRE_LAST  = 5'd19;  // 10 bytes x 2 cycles
    localparam logic [3:0] c_LAST_STEP = 4'd9;
    localparam logic [3:0] c_LAST_PTRN = 4'd8;
    localparam logic [3:0] c_NO_PTRN   = 4'hF;

    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        lfsr_step = {s[5:0], ^(s & t)};
    endfunction

    state_t     r_state;
    state_t     w_next;

    logic [4:0] r_cnt;          // preload cycle counter; bit 0 = capture phase
    logic [6:0] r_buf [0:9];    // preamble bytes, low 7 bits
    logic [3:0] r_p;            // pattern under test
    logic [3:0] r_i;            // preamble step under test (1..9)
    logic [6:0] r_s;            // search LFSR state
    logic [5:0] r_idx;          // decrypt byte index, run ends on its wrap
    logic       r_phase;        // 0 = read cycle, 1 = write cycle
    logic [6:0] r_lfsr;         // decrypt keystream state
    logic [3:0] r_ptrn_idx;
    logic [6:0] r_seed;

    logic [6:0] w_seed;
    logic [6:0] w_s_step;
    logic       w_match;

    // Preamble plaintext is all spaces, so every buffered byte XOR space is
    // the keystream value the candidate LFSR must reproduce.
    assign w_seed   = r_buf[0] ^ c_SPACE;
    assign w_s_step = lfsr_step(r_s, tap_of(r_p));
    assign w_match  = (w_s_step == (r_buf[r_i] ^ c_SPACE));

    assign ptrn_idx  = r_ptrn_idx;
    assign lfsr_seed = r_seed;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and Moore outputs. Every way back into ARM happens with Start
    // high (or from reset, which counts as Start seen high), so ARM only has
    // to wait for Start low to launch.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        Ack         = 1'b0;
        Fail        = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (r_state)
            ST_ARM: begin
                if (!Start) w_next = ST_PRELOAD;
            end
            ST_PRELOAD: begin
                mem_addr = c_CT_BASE + {4'd0, r_cnt[4:1]};
                if (Start)                    w_next = ST_ARM;
                else if (r_cnt == c_PRE_LAST) w_next = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (Start)                                    w_next = ST_ARM;
                else if (w_match && (r_i == c_LAST_STEP))     w_next = ST_DECRYPT;
                else if (!w_match && (r_p == c_LAST_PTRN))    w_next = ST_FAIL;
            end
            ST_DECRYPT: begin
                if (!r_phase) begin
                    mem_addr = c_CT_BASE + {2'b00, r_idx};
                end else begin
                    mem_addr    = {2'b00, r_idx};
                    mem_wr_en   = 1'b1;
                    mem_wr_data = {1'b0, mem_rd_data[6:0] ^ r_lfsr};
                end
                if (Start)                               w_next = ST_ARM;
                else if (r_phase && (r_idx == 6'd63))    w_next = ST_DONE;
            end
            ST_DONE: begin
                Ack = 1'b1;
                if (Start) w_next = ST_ARM;
            end
            ST_FAIL: begin
                Ack  = 1'b1;
                Fail = 1'b1;
                if (Start) w_next = ST_ARM;
            end
            default: begin
                w_next = ST_ARM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_i        <= '0;
            r_s        <= '0;
            r_idx      <= '0;
            r_phase    <= 1'b0;
            r_lfsr     <= '0;
            r_ptrn_idx <= '0;
            r_seed     <= '0;
            for (int k = 0; k < 10; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_ARM: begin
                    r_cnt <= '0;
                end
                ST_PRELOAD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt[0]) begin
                        r_buf[r_cnt[4:1]] <= mem_rd_data[6:0];
                    end
                    if (r_cnt == c_PRE_LAST) begin
                        r_p <= '0;
                        r_i <= 4'd1;
                        r_s <= w_seed;
                    end
                end
                ST_SEARCH: begin
                    if (w_match) begin
                        if (r_i == c_LAST_STEP) begin
                            r_ptrn_idx <= r_p;
                            r_seed     <= w_seed;
                            r_lfsr     <= w_seed;
                            r_idx      <= '0;
                            r_phase    <= 1'b0;
                        end else begin
                            r_i <= r_i + 4'd1;
                            r_s <= w_s_step;
                        end
                    end else begin
                        // Restart from the seed with the next candidate.
                        r_p <= r_p + 4'd1;
                        r_i <= 4'd1;
                        r_s <= w_seed;
                        if (r_p == c_LAST_PTRN) begin
                            r_ptrn_idx <= c_NO_PTRN;
                        end
                    end
                end
                ST_DECRYPT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_idx  <= r_idx + 6'd1;
                        r_lfsr <= lfsr_step(r_lfsr, tap_of(r_ptrn_idx));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional ciphertext parity checker (bit 7 must equal XOR of bits 6:0)
    // ------------------------------------------------------------------------
`ifdef DECRYPT_PARITY_CHK_EN
    logic [6:0] r_parity_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_parity_cnt <= '0;
        end else if ((r_state == ST_ARM) && !Start) begin
            r_parity_cnt <= '0;
        end else if ((r_state == ST_DECRYPT) && r_phase &&
                     (mem_rd_data[7] != ^mem_rd_data[6:0]) &&
                     (r_parity_cnt != 7'd64)) begin
            r_parity_cnt <= r_parity_cnt + 7'd1;
        end
    end

    assign parity_err_cnt = r_parity_cnt;
`else
    logic w_unused_parity_bit;

    assign w_unused_parity_bit = mem_rd_data[7];
    assign parity_err_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt_sequencer
// Purpose  : Self-checking bench for decrypt_sequencer. Builds ciphertext
//            images from known plaintext, models the expected pattern search,
//            and checks every memory write plus run results.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decrypt_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       Fail;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] ptrn_idx;
    logic [6:0] lfsr_seed;
    logic [6:0] parity_err_cnt;

    decrypt_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .Ack            (Ack),
        .Fail           (Fail),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .ptrn_idx       (ptrn_idx),
        .lfsr_seed      (lfsr_seed),
        .parity_err_cnt (parity_err_cnt)
    );

    always #5 Clk = ~Clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    logic [7:0] img    [256];   // image loaded into memory before a run
    logic [7:0] dm     [256];   // the data memory itself
    logic [7:0] exp_pt [64];    // plaintext the run must produce
    logic [6:0] taps   [9];
    logic       ld = 1'b0;

`ifdef DECRYPT_PARITY_CHK_EN
    localparam int c_EXP_PAR = 1;
`else
    localparam int c_EXP_PAR = 0;
`endif

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Synchronous data memory: read data one cycle after the address.
    always @(posedge Clk) begin
        if (ld) begin
            for (int k = 0; k < 256; k++) dm[k] <= img[k];
        end else if (mem_wr_en) begin
            dm[mem_addr] <= mem_wr_data;
        end
        mem_rd_data <= dm[mem_addr];
    end

    // Every write must land in 0..63 and carry the expected plaintext byte.
    always @(negedge Clk) begin
        if (Reset && mem_wr_en) begin
            wr_cnt++;
            chk("wr_addr_range", {31'd0, mem_addr < 8'd64}, 32'd1);
            chk("wr_data", {24'd0, mem_wr_data}, {24'd0, exp_pt[mem_addr[5:0]]});
        end
    end

    // Plaintext = prelen spaces, message, space padding; encrypted into 64..127
    // with good parity in bit 7.
    task automatic build(input int p, input logic [6:0] seed, input int prelen, input string msg);
        logic [6:0] l;
        logic [6:0] c;
        logic [7:0] pt;
        l = seed;
        for (int k = 0; k < 256; k++) img[k] = (k < 64) ? 8'hEE : 8'h00;
        for (int k = 0; k < 64; k++) begin
            if (k < prelen)                   pt = 8'h20;
            else if (k - prelen < msg.len())  pt = msg[k - prelen];
            else                              pt = 8'h20;
            exp_pt[k]   = pt;
            c           = pt[6:0] ^ l;
            img[64 + k] = {^c, c};
            l           = step(l, taps[p]);
        end
    endtask

    // First pattern whose keystream reproduces all nine preamble steps,
    // and how many search cycles the trial-and-abort walk costs.
    function automatic void model_search(output int p_sel, output int cyc);
        logic [6:0] seed;
        logic [6:0] s;
        bit ok;
        seed  = img[64][6:0] ^ 7'h20;
        p_sel = 15;
        cyc   = 0;
        for (int p = 0; p < 9; p++) begin
            s  = seed;
            ok = 1'b1;
            for (int i = 1; i <= 9; i++) begin
                s = step(s, taps[p]);
                cyc++;
                if (s != (img[64 + i][6:0] ^ 7'h20)) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) begin
                p_sel = p;
                return;
            end
        end
    endfunction

    task automatic load_mem();
        @(negedge Clk);
        ld = 1'b1;
        @(negedge Clk);
        ld = 1'b0;
    endtask

    // Drop Start and count edges after the launching edge until Ack.
    task automatic do_run(output int lat, output bit to);
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        lat = 0;
        to  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge Clk);
            #1;
            lat++;
            if (Ack) begin
                to = 1'b0;
                break;
            end
        end
        chk("ack_timeout", {31'd0, to}, 32'd0);
    endtask

    task automatic rearm();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        chk("ack_clear", {31'd0, Ack}, 32'd0);
    endtask

    task automatic check_dm(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) if (dm[k] !== exp_pt[k]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic check_ok_run(input string nm, input int p_exp);
        chk({nm, "_ack"}, {31'd0, Ack}, 32'd1);
        chk({nm, "_fail"}, {31'd0, Fail}, 32'd0);
        chk({nm, "_ptrn"}, {28'd0, ptrn_idx}, p_exp);
        chk({nm, "_seed"}, {25'd0, lfsr_seed}, {25'd0, img[64][6:0] ^ 7'h20});
        chk({nm, "_writes"}, wr_cnt, 64);
        check_dm({nm, "_dm"});
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_ack"}, {31'd0, Ack}, 32'd0);
        chk({nm, "_fail"}, {31'd0, Fail}, 32'd0);
        chk({nm, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({nm, "_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({nm, "_wr_data"}, {24'd0, mem_wr_data}, 32'd0);
        chk({nm, "_ptrn"}, {28'd0, ptrn_idx}, 32'd0);
        chk({nm, "_seed"}, {25'd0, lfsr_seed}, 32'd0);
        chk({nm, "_par"}, {25'd0, parity_err_cnt}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit to;
        int p_m;
        int s_m;
        string msg_a;
        msg_a = "Wads has worked once again";
        taps[0] = 7'h60; taps[1] = 7'h48; taps[2] = 7'h78;
        taps[3] = 7'h72; taps[4] = 7'h6A; taps[5] = 7'h69;
        taps[6] = 7'h5C; taps[7] = 7'h7E; taps[8] = 7'h7B;

        Reset = 1'b0;
        Start = 1'b1;
        #3;
        check_reset_outs("rst");
        repeat (3) @(negedge Clk);
        Reset = 1'b1;

        // Pattern 7, seed 0x01, 10-byte preamble.
        build(7, 7'h01, 10, msg_a);
        load_mem();
        model_search(p_m, s_m);
        chk("a_model_ptrn", p_m, 7);
        wr_cnt = 0;
        do_run(lat, to);
        check_ok_run("a", p_m);
        chk("a_ptrn_lit", {28'd0, ptrn_idx}, 32'd7);
        chk("a_seed_lit", {25'd0, lfsr_seed}, 32'h01);
        chk("a_dm10_lit", {24'd0, dm[10]}, 32'h57);
        chk("a_dm63_lit", {24'd0, dm[63]}, 32'h20);
        chk("a_par", {25'd0, parity_err_cnt}, 32'd0);
        chk("a_latency", lat, 148 + s_m);
        rearm();

        // Pattern 0, seed 0x7F, all spaces; pattern 0 is tried first, so 9
        // search cycles and Ack 20 + 9 + 128 edges after launch.
        build(0, 7'h7F, 15, "");
        load_mem();
        model_search(p_m, s_m);
        wr_cnt = 0;
        do_run(lat, to);
        check_ok_run("b", p_m);
        chk("b_ptrn_lit", {28'd0, ptrn_idx}, 32'd0);
        chk("b_latency", lat, 148 + s_m);
        chk("b_latency_lit", lat, 157);
        rearm();

        // Corrupted preamble: no pattern fits.
        build(7, 7'h01, 10, msg_a);
        img[66] = img[66] ^ 8'h01;
        load_mem();
        model_search(p_m, s_m);
        wr_cnt = 0;
        do_run(lat, to);
        chk("c_ack", {31'd0, Ack}, 32'd1);
        chk("c_fail", {31'd0, Fail}, 32'd1);
        chk("c_ptrn", {28'd0, ptrn_idx}, p_m);
        chk("c_ptrn_lit", {28'd0, ptrn_idx}, 32'hF);
        chk("c_writes", wr_cnt, 0);
        chk("c_dm0", {24'd0, dm[0]}, 32'hEE);
        rearm();

        // Abort at decrypt byte 20, then rerun to completion.
        build(7, 7'h01, 10, msg_a);
        load_mem();
        model_search(p_m, s_m);
        wr_cnt = 0;
        @(negedge Clk);
        Start = 1'b0;
        to = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(posedge Clk);
            if (wr_cnt == 20) begin
                to = 1'b0;
                break;
            end
        end
        chk("d_wait_timeout", {31'd0, to}, 32'd0);
        #1;
        Start = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        chk("d_abort_ack", {31'd0, Ack}, 32'd0);
        chk("d_abort_writes", wr_cnt, 20);
        chk("d_dm19", {24'd0, dm[19]}, {24'd0, exp_pt[19]});
        chk("d_dm20", {24'd0, dm[20]}, 32'hEE);
        wr_cnt = 0;
        do_run(lat, to);
        check_ok_run("d", p_m);
        rearm();

        // Bad parity on byte 80 (plaintext index 16 = 'a').
        build(7, 7'h01, 10, msg_a);
        img[80] = img[80] ^ 8'h80;
        load_mem();
        model_search(p_m, s_m);
        wr_cnt = 0;
        do_run(lat, to);
        check_ok_run("e", p_m);
        chk("e_par", {25'd0, parity_err_cnt}, c_EXP_PAR);
        chk("e_dm16_lit", {24'd0, dm[16]}, 32'h61);
        rearm();

        // Reset mid-search, then a clean run.
        build(7, 7'h01, 10, msg_a);
        load_mem();
        model_search(p_m, s_m);
        @(negedge Clk);
        Start = 1'b0;
        repeat (23) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outs("f_rst");
        Start = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("f_idle_ack", {31'd0, Ack}, 32'd0);
        load_mem();
        wr_cnt = 0;
        do_run(lat, to);
        check_ok_run("f", p_m);
        chk("f_latency", lat, 148 + s_m);
        rearm();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
